// File: rtl/mdu_seq_pkg.sv
// rtl/mdu_seq_pkg.sv - shared op codes, state encoding and widths for the mul/div sequencer
package mdu_seq_pkg;

  localparam int MDU_WIDTH  = 32;
  localparam int MDU_RES_WD = 2 * MDU_WIDTH;

  localparam logic [1:0] MDU_OP_MULTU = 2'b00;
  localparam logic [1:0] MDU_OP_MULT  = 2'b01;
  localparam logic [1:0] MDU_OP_DIVU  = 2'b10;
  localparam logic [1:0] MDU_OP_DIV   = 2'b11;

  typedef enum logic [1:0] {
    MDU_ST_IDLE = 2'b00,
    MDU_ST_DIVZ = 2'b01,
    MDU_ST_RUN  = 2'b10,
    MDU_ST_DONE = 2'b11
  } mdu_state_t;

endpackage

// File: rtl/mdu_seq_step.sv
// rtl/mdu_seq_step.sv - one combinational shift-add / restoring-divide iteration
module mdu_step #(
  parameter int WIDTH = 32
) (
  input  logic               div,
  input  logic [2*WIDTH:0]   part,
  input  logic [2*WIDTH-1:0] opnd,
  input  logic               sel,
  output logic [2*WIDTH:0]   part_next,
  output logic               qbit
);

  logic [2*WIDTH:0] shifted;
  logic [2*WIDTH:0] diff;

  always_comb begin
    shifted   = {part[2*WIDTH-1:0], sel};
    diff      = shifted - {1'b0, opnd};
    qbit      = 1'b0;
    part_next = part;
    if (div) begin
      // Partial remainder never exceeds WIDTH+1 bits, so the top bit is a clean borrow
      qbit      = ~diff[2*WIDTH];
      part_next = qbit ? diff : shifted;
    end else if (sel) begin
      part_next = part + {1'b0, opnd};
    end
  end

endmodule

// File: rtl/mdu_seq.sv
// rtl/mdu_seq.sv - iterative MULT/MULTU/DIV/DIVU sequencer returning {hi,lo}
module mdu_seq
  import mdu_seq_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   opdata1,
  input  logic [WIDTH-1:0]   opdata2,
  input  logic               annul,
  output logic               stallreq,
  output logic               ready,
  output logic [2*WIDTH-1:0] result,
  output logic               busy
);

  localparam int CW = $clog2(WIDTH);

  mdu_state_t         state, state_next;
  logic [CW-1:0]      cnt;
  logic [1:0]         op_r;
  logic               sgn1, sgn2;
  logic [2*WIDTH:0]   part;
  logic [2*WIDTH-1:0] opnd;
  logic [WIDTH-1:0]   dq;

  logic               neg1, neg2;
  logic [WIDTH-1:0]   mag1, mag2;
  logic               is_div, sel, step_q;
  logic [2*WIDTH:0]   step_part;
  logic [WIDTH-1:0]   quot, rem;
  logic [2*WIDTH-1:0] prod, fixed;

  assign stallreq = start & ~ready & ~annul;

  assign neg1   = op[0] & opdata1[WIDTH-1];
  assign neg2   = op[0] & opdata2[WIDTH-1];
  assign mag1   = neg1 ? -opdata1 : opdata1;
  assign mag2   = neg2 ? -opdata2 : opdata2;
  assign is_div = op_r[1];
  assign sel    = is_div ? dq[WIDTH-1] : dq[0];

  mdu_step #(.WIDTH(WIDTH)) u_step (
    .div       (is_div),
    .part      (part),
    .opnd      (opnd),
    .sel       (sel),
    .part_next (step_part),
    .qbit      (step_q)
  );

  // Final iteration results, sign-corrected for the signed ops
  always_comb begin
    quot = {dq[WIDTH-2:0], step_q};
    rem  = step_part[WIDTH-1:0];
    prod = step_part[2*WIDTH-1:0];
    if (is_div) begin
      fixed = {(op_r[0] & sgn1) ? -rem : rem,
               (op_r[0] & (sgn1 ^ sgn2)) ? -quot : quot};
    end else begin
      fixed = (op_r[0] & (sgn1 ^ sgn2)) ? -prod : prod;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      MDU_ST_IDLE: if (start) state_next = (op[1] && opdata2 == '0) ? MDU_ST_DIVZ : MDU_ST_RUN;
      MDU_ST_DIVZ: state_next = MDU_ST_DONE;
      MDU_ST_RUN:  if (cnt == CW'(WIDTH - 1)) state_next = MDU_ST_DONE;
      MDU_ST_DONE: if (!start) state_next = MDU_ST_IDLE;
      default:     state_next = MDU_ST_IDLE;
    endcase
    if (annul) state_next = MDU_ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= MDU_ST_IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      op_r   <= '0;
      sgn1   <= 1'b0;
      sgn2   <= 1'b0;
      part   <= '0;
      opnd   <= '0;
      dq     <= '0;
      result <= '0;
      ready  <= 1'b0;
      busy   <= 1'b0;
    end else begin
      ready <= (state_next == MDU_ST_DONE);
      busy  <= (state_next == MDU_ST_DIVZ) || (state_next == MDU_ST_RUN);
      case (state)
        MDU_ST_IDLE: begin
          cnt <= '0;
          if (start && !annul) begin
            op_r <= op;
            sgn1 <= neg1;
            sgn2 <= neg2;
            part <= '0;
            opnd <= {{WIDTH{1'b0}}, op[1] ? mag2 : mag1};
            dq   <= op[1] ? mag1 : mag2;
          end
        end
        MDU_ST_DIVZ: if (!annul) result <= '0;
        MDU_ST_RUN: begin
          cnt  <= cnt + CW'(1);
          part <= step_part;
          if (is_div) begin
            dq <= {dq[WIDTH-2:0], step_q};
          end else begin
            opnd <= opnd << 1;
            dq   <= dq >> 1;
          end
          if (cnt == CW'(WIDTH - 1) && !annul) result <= fixed;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_seq.sv
// tb/tb_mdu_seq.sv - directed and randomized checks of mdu_seq against an arithmetic model
module tb_mdu_seq;

  logic        clk = 1'b0;
  logic        rst, start, annul;
  logic [1:0]  op;
  logic [31:0] opdata1, opdata2;
  logic        stallreq, ready, busy;
  logic [63:0] result;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  mdu_seq dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .opdata1  (opdata1),
    .opdata2  (opdata2),
    .annul    (annul),
    .stallreq (stallreq),
    .ready    (ready),
    .result   (result),
    .busy     (busy)
  );

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] ref_model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] res;
    sa = o[0] ? longint'($signed(a)) : longint'(a);
    sb = o[0] ? longint'($signed(b)) : longint'(b);
    if (!o[1]) begin
      res = 64'(sa * sb);
    end else if (b == 32'd0) begin
      res = 64'd0;
    end else begin
      q   = sa / sb;
      r   = sa % sb;
      res = {r[31:0], q[31:0]};
    end
    return res;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Entered one time unit after a rising edge; returns in the cycle ready is seen
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output logic [63:0] res, output int lat, output int stalls);
    op = o; opdata1 = a; opdata2 = b; start = 1'b1;
    lat = 0; stalls = 0;
    #1;
    while (!ready && lat < 40) begin
      if (stallreq) stalls++;
      @(posedge clk);
      #2;
      lat++;
    end
    chk("stallreq_low_at_ready", 64'(stallreq), 64'd0);
    res = result;
  endtask

  task automatic end_op();
    tick();
    start = 1'b0;
    tick();
  endtask

  initial begin
    logic [63:0] res;
    int          lat, stalls;
    logic        saw_ready;
    logic [1:0]  o;
    logic [31:0] a, b;
    int          kind;

    rst = 1'b1; start = 1'b0; annul = 1'b0; op = 2'b00; opdata1 = '0; opdata2 = '0;
    tick();
    tick();
    rst = 1'b0;
    chk("reset_ready", 64'(ready), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_result", result, 64'd0);
    chk("reset_stallreq", 64'(stallreq), 64'd0);

    run_op(2'b10, 32'd100, 32'd7, res, lat, stalls);
    chk("divu_latency", 64'(lat), 64'd33);
    chk("divu_stall_cycles", 64'(stalls), 64'd33);
    chk("divu_100_7", res, {32'h00000002, 32'h0000000E});
    end_op();

    run_op(2'b11, 32'hFFFFFFF9, 32'd2, res, lat, stalls);
    chk("div_m7_2", res, {32'hFFFFFFFF, 32'hFFFFFFFD});
    end_op();
    run_op(2'b11, 32'h80000000, 32'hFFFFFFFF, res, lat, stalls);
    chk("div_min_m1", res, {32'h00000000, 32'h80000000});
    end_op();
    run_op(2'b01, 32'hFFFFFFFD, 32'd5, res, lat, stalls);
    chk("mult_m3_5", res, 64'hFFFFFFFF_FFFFFFF1);
    chk("mult_latency", 64'(lat), 64'd33);
    end_op();
    run_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, res, lat, stalls);
    chk("multu_max", res, {32'hFFFFFFFE, 32'h00000001});
    end_op();

    // Divide by zero, start held past completion
    run_op(2'b10, 32'h12345678, 32'd0, res, lat, stalls);
    chk("divz_latency", 64'(lat), 64'd2);
    chk("divz_result", res, 64'd0);
    tick();
    chk("divz_hold_ready_t3", 64'(ready), 64'd1);
    chk("divz_hold_busy_t3", 64'(busy), 64'd0);
    tick();
    chk("divz_hold_ready_t4", 64'(ready), 64'd1);
    tick();
    start = 1'b0;
    #1;
    chk("divz_ready_t5", 64'(ready), 64'd1);
    tick();
    chk("divz_idle_ready_t6", 64'(ready), 64'd0);
    chk("divz_idle_busy_t6", 64'(busy), 64'd0);

    // Annul mid-divide, then a fresh divide
    op = 2'b11; opdata1 = 32'd1000; opdata2 = 32'd7; start = 1'b1;
    saw_ready = 1'b0;
    for (int t = 0; t < 10; t++) begin
      #1;
      if (ready) saw_ready = 1'b1;
      tick();
    end
    chk("annul_busy_before", 64'(busy), 64'd1);
    annul = 1'b1;
    #1;
    chk("annul_stallreq", 64'(stallreq), 64'd0);
    tick();
    annul = 1'b0; start = 1'b0;
    if (ready) saw_ready = 1'b1;
    chk("annul_never_ready", 64'(saw_ready), 64'd0);
    chk("annul_idle_busy", 64'(busy), 64'd0);
    tick();
    run_op(2'b10, 32'd9, 32'd3, res, lat, stalls);
    chk("after_annul_latency", 64'(lat), 64'd33);
    chk("after_annul_divu_9_3", res, {32'd0, 32'd3});
    end_op();

    // Reset in the middle of a multiply
    op = 2'b01; opdata1 = 32'd1234; opdata2 = 32'hFFFFFFFB; start = 1'b1;
    repeat (15) tick();
    rst = 1'b1; start = 1'b0;
    tick();
    rst = 1'b0;
    chk("midrun_rst_busy", 64'(busy), 64'd0);
    chk("midrun_rst_ready", 64'(ready), 64'd0);
    chk("midrun_rst_result", result, 64'd0);
    tick();

    for (int i = 0; i < 300; i++) begin
      o = 2'($urandom);
      a = $urandom;
      b = $urandom;
      kind = $urandom_range(0, 9);
      if (kind == 0) b = 32'd0;
      else if (kind == 1) begin a = 32'h80000000; b = 32'hFFFFFFFF; end
      else if (kind == 2) b = 32'($urandom_range(1, 15));
      else if (kind == 3) a = 32'($urandom_range(0, 20));
      run_op(o, a, b, res, lat, stalls);
      chk("rand_result", res, ref_model(o, a, b));
      chk("rand_latency", 64'(lat), (o[1] && b == 32'd0) ? 64'd2 : 64'd33);
      end_op();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
